// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
//   Shared definitions for the instruction-decode stage.
//   - fmt_e      : instruction format code carried on out_fmt
//   - OPC_*      : 7-bit major opcodes recognised by the decoder
//   No ports; imported by imm_gen and imm_decode_stage.
// ---------------------------------------------------------------------------
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Every legal opcode ends in 2'b11, so matching the full 7 bits also
    // rejects compressed-style encodings with instr[1:0] != 2'b11.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Purely combinational format classifier and immediate generator.
//   Parameters:
//     XLEN        - immediate width (32 or 64)
//     ILLEGAL_IMM - value driven for R-format and illegal instructions
//   Ports:
//     i_instr   in  32    raw instruction
//     o_fmt     out 3     format code (fmt_e encoding)
//     o_imm     out XLEN  sign-extended immediate
//     o_illegal out 1     opcode not recognised
// ---------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ILLEGAL_IMM = '0
) (
    input  logic [31:0]     i_instr,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    fmt_e            w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_immExt;

    // Classify the format purely from the major opcode; anything not listed
    // falls through to ILL.
    always_comb begin
        w_fmt = FMT_ILL;
        case (i_instr[6:0])
            OPC_OP:                                             w_fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM,
            OPC_SYSTEM:                                         w_fmt = FMT_I;
            OPC_STORE:                                          w_fmt = FMT_S;
            OPC_BRANCH:                                         w_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                                 w_fmt = FMT_U;
            OPC_JAL:                                            w_fmt = FMT_J;
            default:                                            w_fmt = FMT_ILL;
        endcase
    end

    // Build a 32-bit sign-extended immediate first; widening to XLEN is a
    // separate step so the same field layout serves both datapath widths.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign w_immExt = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign w_immExt = w_imm32;
        end
    endgenerate

    assign o_fmt     = w_fmt;
    assign o_illegal = (w_fmt == FMT_ILL);
    assign o_imm     = (w_fmt == FMT_R || w_fmt == FMT_ILL) ? ILLEGAL_IMM : w_immExt;

endmodule

// File: rtl/imm_decode_stage.sv
// ---------------------------------------------------------------------------
// imm_decode_stage
//   Registered decode stage between fetch and execute with valid/ready on
//   both sides. Decodes format, immediate, register indices and funct fields
//   and passes the PC through with one cycle of latency.
//   Optional feature: define IMM_DECODE_SKID_EN to add a skid entry so that
//   in_ready is registered with no combinational path from out_ready.
//   Ports:
//     clk, rst (sync, active-high), flush
//     in_valid/in_ready/in_instr/in_pc           fetch side
//     out_valid/out_ready                        execute side handshake
//     out_pc, out_fmt, out_imm, out_rd, out_rs1, out_rs2,
//     out_funct3, out_funct7, out_illegal        decoded entry
// ---------------------------------------------------------------------------
module imm_decode_stage
    import decode_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ILLEGAL_IMM = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_illegal
);

    // One decoded entry packed flat: pc, fmt, imm, rd, rs1, rs2, f3, f7, ill.
    localparam int W = 2*XLEN + 29;

    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [W-1:0]    w_newEntry;
    logic            w_outFree;
    logic            w_accept;

    logic [W-1:0]    r_out;
    logic            r_outValid;

    imm_gen #(
        .XLEN        (XLEN),
        .ILLEGAL_IMM (ILLEGAL_IMM)
    ) u_immGen (
        .i_instr   (in_instr),
        .o_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_newEntry = {in_pc, w_fmt, w_imm, in_instr[11:7], in_instr[19:15],
                         in_instr[24:20], in_instr[14:12], in_instr[31:25], w_illegal};

    // The output register can take something this cycle if it is empty or
    // its current entry is leaving.
    assign w_outFree = !r_outValid || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;

`ifdef IMM_DECODE_SKID_EN
    logic [W-1:0] r_skid;
    logic         r_skidValid;

    // in_ready depends only on skid occupancy, so fetch never sees a
    // combinational path from out_ready.
    assign in_ready = !r_skidValid;

    // A held skid entry always moves to the output before new input is
    // taken (in_ready is low while it is held), which keeps ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_outValid  <= 1'b0;
            r_skid      <= '0;
            r_skidValid <= 1'b0;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (r_skidValid) begin
            if (w_outFree) begin
                r_out       <= r_skid;
                r_outValid  <= 1'b1;
                r_skidValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_outFree) begin
                r_out      <= w_newEntry;
                r_outValid <= 1'b1;
            end else begin
                r_skid      <= w_newEntry;
                r_skidValid <= 1'b1;
            end
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end
`else
    assign in_ready = w_outFree;

    // Single entry: load on accept (possibly while the old entry drains),
    // otherwise empty once execute takes the entry. Flush wins over accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_out      <= w_newEntry;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end
`endif

    assign out_valid = r_outValid;
    assign {out_pc, out_fmt, out_imm, out_rd, out_rs1, out_rs2,
            out_funct3, out_funct7, out_illegal} = r_out;

endmodule

// File: tb/tb_imm_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_stage
//   Directed bench for imm_decode_stage. A 32-bit and a 64-bit instance see
//   the same stimulus; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_imm_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal;

    logic [63:0] in_pc64;
    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_pc64;
    logic [2:0]  out_fmt64;
    logic [63:0] out_imm64;
    logic [4:0]  out_rd64;
    logic [4:0]  out_rs164;
    logic [4:0]  out_rs264;
    logic [2:0]  out_funct364;
    logic [6:0]  out_funct764;
    logic        out_illegal64;

    int checks   = 0;
    int failures = 0;

    assign in_pc64 = {32'hA5A5_0000, in_pc};

    imm_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .out_fmt(out_fmt64), .out_imm(out_imm64), .out_rd(out_rd64), .out_rs1(out_rs164),
        .out_rs2(out_rs264), .out_funct3(out_funct364), .out_funct7(out_funct764),
        .out_illegal(out_illegal64)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single edge; called at a falling edge
    // and returns at the next falling edge with in_valid dropped.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    function automatic logic [31:0] mkInstr(input int k);
        logic [11:0] v;
        v = 12'(k + 1);
        return {v, 5'd0, 3'd0, v[4:0], 7'h13};
    endfunction

    // Push 8 addi instructions through while out_ready follows pat. Every
    // delivered entry must match the next expected pc/imm, and an entry held
    // under out_ready=0 must look identical on the following cycle.
    task automatic runStream(input logic [15:0] pat, output int cycles, output int recv);
        int          sent;
        logic        prevHold;
        logic [31:0] prevPc;
        logic [31:0] prevImm;
        sent     = 0;
        recv     = 0;
        cycles   = 0;
        prevHold = 1'b0;
        prevPc   = '0;
        prevImm  = '0;
        while (recv < 8 && cycles < 100) begin
            out_ready = pat[cycles % 16];
            in_valid  = (sent < 8);
            in_instr  = mkInstr(sent);
            in_pc     = 32'h2000 + 32'(sent * 4);
            #1;
            if (prevHold) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_pc", 64'(out_pc), 64'(prevPc));
                checkOutput("stall_imm", 64'(out_imm), 64'(prevImm));
            end
            prevHold = out_valid && !out_ready;
            prevPc   = out_pc;
            prevImm  = out_imm;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_pc%0d", recv), 64'(out_pc), 64'(32'h2000 + 32'(recv * 4)));
                checkOutput($sformatf("stream_imm%0d", recv), 64'(out_imm), 64'(recv + 1));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int cycles;
        int recv;

        //                instr          fmt   imm32          imm64                   rd     rs1    rs2    f3    ill
        vecs[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd1,  5'd0,  5'd31, 3'd0, 1'b0};
        vecs[1] = '{32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5'd1,  5'd31, 5'd29, 3'd7, 1'b0};
        vecs[2] = '{32'h00000463, 3'd3, 32'h00000008, 64'h0000000000000008, 5'd8,  5'd0,  5'd0,  3'd0, 1'b0};
        vecs[3] = '{32'h123452B7, 3'd4, 32'h12345000, 64'h0000000012345000, 5'd5,  5'd8,  5'd3,  3'd5, 1'b0};
        vecs[4] = '{32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 5'd5,  5'd0,  5'd0,  3'd0, 1'b0};
        vecs[5] = '{32'h0020A423, 3'd2, 32'h00000008, 64'h0000000000000008, 5'd8,  5'd1,  5'd2,  3'd2, 1'b0};
        vecs[6] = '{32'h0000007F, 3'd7, 32'h00000000, 64'h0000000000000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b1};
        vecs[7] = '{32'h00000033, 3'd0, 32'h00000000, 64'h0000000000000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0};
        vecs[8] = '{32'h00000010, 3'd7, 32'h00000000, 64'h0000000000000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b1};
        vecs[9] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5'd29, 5'd0,  5'd0,  3'd0, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_imm", 64'(out_imm), 64'd0);
        checkOutput("rst_fmt", 64'(out_fmt), 64'd0);
        checkOutput("rst_imm64", out_imm64, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_in_ready64", 64'(in_ready64), 64'd1);

        // Directed decode vectors, one at a time with a drain cycle between.
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("v%0d_pre_valid", i), 64'(out_valid), 64'd0);
            applyStimulus(vecs[i].instr, 32'h100 + 32'(i * 4), 1'b1);
            checkOutput($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h100 + 32'(i * 4)));
            checkOutput($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
            checkOutput($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm32));
            checkOutput($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            checkOutput($sformatf("v%0d_rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
            checkOutput($sformatf("v%0d_rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
            checkOutput($sformatf("v%0d_f3", i), 64'(out_funct3), 64'(vecs[i].f3));
            checkOutput($sformatf("v%0d_f7", i), 64'(out_funct7), 64'(vecs[i].instr >> 25));
            checkOutput($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
            checkOutput($sformatf("v%0d_imm64", i), out_imm64, vecs[i].imm64);
            checkOutput($sformatf("v%0d_fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt));
            checkOutput($sformatf("v%0d_pc64", i), out_pc64, {32'hA5A5_0000, 32'h100 + 32'(i * 4)});
            @(negedge clk);
        end

        // Stream with a stalling consumer, then full throughput.
        runStream(16'b0110_1001_1101_0011, cycles, recv);
        checkOutput("stream_stall_count", 64'(recv), 64'd8);
        runStream(16'hFFFF, cycles, recv);
        checkOutput("stream_full_count", 64'(recv), 64'd8);
        checkOutput("stream_full_cycles", 64'(cycles), 64'd9);
        checkOutput("stream_empty", 64'(out_valid), 64'd0);

        // Flush with an entry held and a new input presented in the same cycle.
        applyStimulus(32'hFFF00093, 32'h300, 1'b0);
        checkOutput("flush_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("flush_pre_pc", 64'(out_pc), 64'h300);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000463;
        in_pc    = 32'h304;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        checkOutput("flush_dropped", 64'(out_valid), 64'd0);

        // Reset in the middle of traffic, with an input offered during reset.
        applyStimulus(32'hFFDFF0EF, 32'h400, 1'b0);
        checkOutput("mrst_pre_valid", 64'(out_valid), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0020A423;
        in_pc    = 32'h404;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("mrst_valid", 64'(out_valid), 64'd0);
        checkOutput("mrst_pc", 64'(out_pc), 64'd0);
        checkOutput("mrst_fmt", 64'(out_fmt), 64'd0);
        checkOutput("mrst_imm", 64'(out_imm), 64'd0);
        checkOutput("mrst_rd", 64'(out_rd), 64'd0);
        checkOutput("mrst_rs1", 64'(out_rs1), 64'd0);
        checkOutput("mrst_rs2", 64'(out_rs2), 64'd0);
        checkOutput("mrst_f3", 64'(out_funct3), 64'd0);
        checkOutput("mrst_f7", 64'(out_funct7), 64'd0);
        checkOutput("mrst_ill", 64'(out_illegal), 64'd0);
        checkOutput("mrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mrst_imm64", out_imm64, 64'd0);
        checkOutput("mrst_pc64", out_pc64, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered instruction-decode stage that sits between fetch and execute.
- Classifies the instruction format from the opcode, extracts register indices and funct fields, and produces an XLEN-wide sign-extended immediate.
- Flags illegal opcodes and passes the PC through.
- Uses a valid/ready handshake on both sides, so fetch and execute can stall independently.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. Immediates sign-extend to XLEN; the PC is XLEN wide.
- ILLEGAL_IMM, 0, value driven on out_imm when the instruction is illegal or has no immediate.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discards all held entries
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts the entry
- out_pc  out  XLEN  registered copy of in_pc
- out_fmt  out  3  format code (fmt_e)
- out_imm  out  XLEN  decoded immediate
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_illegal  out  1  opcode not recognised, or instr[1:0] != 2'b11

Behaviour:
- Reset: on a rising clk edge with rst=1, every out_* register clears to 0, including out_valid. in_ready is 1 on the first cycle after reset.
- Opcode to format mapping:
  - OP → R
  - OP-IMM, LOAD, JALR, MISC-MEM, SYSTEM → I
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
  - any other opcode → ILL (out_illegal=1)
- Immediate construction (s = instr[31], each field sign-extended to XLEN):
  - I: {s.., instr[31:20]}
  - S: {s.., instr[31:25], instr[11:7]}
  - B: {s.., instr[7], instr[30:25], instr[11:8], 0}
  - U: {s.., instr[31:12], 12'b0}; for XLEN=64, bit 31 is replicated into [63:32]
  - J: {s.., instr[19:12], instr[20], instr[30:21], 0}
  - R and ILL: ILLEGAL_IMM
- Field extraction: rd, rs1, rs2, funct3 and funct7 are always extracted raw, regardless of format. Consumers use fmt to decide which fields are meaningful.
- Latency: exactly 1 cycle from an accepted input to out_valid.
- Handshake:
  - A transfer occurs when valid && ready are both high at the clock edge.
  - in_ready = !out_valid || out_ready (combinational, baseline configuration).
  - A new entry may be accepted in the same cycle the held entry drains; full throughput is 1 instruction per clock.
  - While out_valid=1 && out_ready=0, all out_* signals hold stable.
- Flush: has priority over acceptance. After the edge, out_valid=0 and any input presented in that cycle is dropped. Data registers may keep stale values.
- rst asserted mid-stream behaves like flush and additionally zeroes all data outputs.
- Illegal instructions are passed downstream as normal entries with out_illegal=1; this block does not stall on them.

Optional Feature:
- Macro: IMM_DECODE_SKID_EN.
- Defined:
  - A second skid entry is added, and in_ready becomes a pure register (= skid entry empty), with no combinational path from out_ready.
  - When out_ready drops while an input is being accepted, that input is captured in the skid entry.
  - The skid entry drains into the output register before any new input is taken.
  - Ordering is preserved.
  - Flush clears both entries.
  - Latency is still 1 cycle when there is no stall.
- Undefined: single entry, with combinational in_ready as described above.

Decomposition:
- Package decode_pkg:
  - fmt_e enum: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
  - 7-bit opcode constants: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM
- Sub-module imm_gen: purely combinational. Maps instr to {fmt, imm, illegal}, parametrised by XLEN. The stage module holds all handshake and register logic and instantiates imm_gen once.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32 → 1 cycle later: fmt=I, imm=0xFFFFFFFF, rd=1, rs1=0.
- 0xFFDFF0EF (jal ra,-4) → fmt=J, imm=0xFFFFFFFC. 0x00000463 (beq x0,x0,8) → fmt=B, imm=0x00000008.
- 0x123452B7 (lui x5,0x12345): XLEN=32 → imm=0x12345000; XLEN=64 with 0x800002B7 → imm=0xFFFFFFFF80000000.
- 0x0020A423 (sw x2,8(x1)) → fmt=S, imm=8, rs1=1, rs2=2. 0x0000007F → illegal=1, fmt=ILL, imm=ILLEGAL_IMM.
- Back-to-back stream of 8 instructions with out_ready toggled pseudo-randomly → no loss or duplication, order kept, outputs stable while stalled, throughput 1/clk when out_ready=1.
- flush and in_valid asserted in the same cycle with an entry held → out_valid=0 next cycle, the input is dropped. rst mid-stream → all outputs 0 and in_ready=1 next cycle.
